// File: rtl/md_issue_ctrl.sv
// E-stage issue and hazard controller for the multiply/divide unit: owns the E slot,
// launches operations, stalls D while the unit is occupied and shadow-checks busy timing.
module md_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [3:0]       d_md_op,
    input  logic             stall_other,
    input  logic             e_flush,
    input  logic             md_busy,
    output logic             md_start,
    output logic [3:0]       md_op_E,
    output logic             stall_D,
    output logic             protocol_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int EXP_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       md_op_E_q, md_op_E_d;
    logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
    logic             protocol_err_q, protocol_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             md_d;
    logic             start_e;
    logic             err_set;
    logic [EXP_W-1:0] exp_load;

    // Pipeline-side decode: everything here is combinational from inputs and the E slot.
    always_comb begin
        md_d     = d_valid && (d_md_op != OP_NONE) && (d_md_op <= OP_MTLO);
        start_e  = (md_op_E_q != OP_NONE) && (md_op_E_q <= OP_DIVU);
        stall_D  = md_d && (start_e || md_busy);
        exp_load = (md_op_E_q <= OP_MULTU) ? EXP_W'(MULT_CYCLES) : EXP_W'(DIV_CYCLES);
    end

    // A flushed mult/div still launches this cycle; only the slot content is dropped.
    always_comb begin
        md_op_E_d = OP_NONE;
        if (e_flush) begin
            md_op_E_d = OP_NONE;
        end else if (stall_D || stall_other) begin
            md_op_E_d = OP_NONE;
        end else if (md_d) begin
            md_op_E_d = d_md_op;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            md_op_E_q      <= OP_NONE;
            exp_cnt_q      <= '0;
            protocol_err_q <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            md_op_E_q      <= md_op_E_d;
            exp_cnt_q      <= exp_cnt_d;
            protocol_err_q <= protocol_err_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    // Next-state logic. The unit raises busy on the cycle after the start, so LAUNCH
    // already consumes one busy cycle of the expected latency.
    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_e) begin
                    state_d   = ST_LAUNCH;
                    exp_cnt_d = exp_load;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_BUSY;
                if (md_busy && (exp_cnt_q != '0)) begin
                    exp_cnt_d = exp_cnt_q - EXP_W'(1);
                end
            end
            ST_BUSY: begin
                if (md_busy) begin
                    if (exp_cnt_q != '0) begin
                        exp_cnt_d = exp_cnt_q - EXP_W'(1);
                    end
                end else if (exp_cnt_q == '0 && start_e) begin
                    state_d   = ST_LAUNCH;
                    exp_cnt_d = exp_load;
                end else begin
                    // Normal completion, or an early release that has just been flagged.
                    state_d   = ST_IDLE;
                    exp_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                exp_cnt_d = '0;
            end
        endcase
    end

    // Output logic: protocol checking and stall accounting.
    always_comb begin
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: err_set = md_busy;
            ST_BUSY: err_set = (md_busy && (exp_cnt_q == '0)) ||
                               (!md_busy && (exp_cnt_q != '0));
            default: err_set = 1'b0;
        endcase
        protocol_err_d = protocol_err_q || err_set;
        stall_cnt_d    = stall_D ? (stall_cnt_q + CNT_W'(1)) : stall_cnt_q;
    end

    assign md_start     = start_e;
    assign md_op_E      = md_op_E_q;
    assign protocol_err = protocol_err_q;
    assign stall_cnt    = stall_cnt_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small multiply/divide unit model that can
// misbehave on request (short busy, spurious busy).
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        d_valid = 1'b0;
    logic [3:0]  d_md_op = 4'd0;
    logic        stall_other = 1'b0;
    logic        e_flush = 1'b0;
    logic        md_busy;
    logic        md_start;
    logic [3:0]  md_op_E;
    logic        stall_D;
    logic        protocol_err;
    logic [31:0] stall_cnt;
    logic [1:0]  dbg_state;

    int          total = 0;
    int          bad = 0;
    int          ucnt;
    int          short_len = 0;
    logic        force_busy = 1'b0;

    md_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .d_md_op      (d_md_op),
        .stall_other  (stall_other),
        .e_flush      (e_flush),
        .md_busy      (md_busy),
        .md_start     (md_start),
        .md_op_E      (md_op_E),
        .stall_D      (stall_D),
        .protocol_err (protocol_err),
        .stall_cnt    (stall_cnt),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Unit model: latches the op on the start edge, then busy for its latency.
    always @(posedge clk or negedge reset) begin
        if (!reset) ucnt <= 0;
        else if (md_start) ucnt <= (short_len != 0) ? short_len : ((md_op_E <= 4'd2) ? 5 : 10);
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end
    assign md_busy = (ucnt != 0) || force_busy;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b0;
        #1;
        chk("rst_err", 32'(protocol_err), 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_state", 32'(dbg_state), 0);
        reset = 1'b1;
    endtask

    initial begin
        // Reset values while held in reset
        #1;
        chk("reset_start", 32'(md_start), 0);
        chk("reset_opE", 32'(md_op_E), 0);
        chk("reset_stall", 32'(stall_D), 0);
        chk("reset_err", 32'(protocol_err), 0);
        chk("reset_cnt", stall_cnt, 0);
        #2 reset = 1'b1;
        tick();

        // mult then mflo
        d_valid = 1'b1; d_md_op = 4'd1;
        #1 chk("t1_pre_stall", 32'(stall_D), 0);
        tick();
        d_md_op = 4'd6;
        #1;
        chk("t1_start", 32'(md_start), 1);
        chk("t1_opE", 32'(md_op_E), 1);
        chk("t1_stall_t", 32'(stall_D), 1);
        for (int i = 1; i <= 5; i++) begin
            tick(); #1;
            chk("t1_stall_busy", 32'(stall_D), 1);
            chk("t1_start_off", 32'(md_start), 0);
            chk("t1_state", 32'(dbg_state), (i == 1) ? 1 : 2);
        end
        tick(); #1;
        chk("t1_release", 32'(stall_D), 0);
        chk("t1_bubble", 32'(md_op_E), 0);
        tick();
        d_valid = 1'b0;
        #1;
        chk("t1_mflo_in_e", 32'(md_op_E), 6);
        chk("t1_mflo_nostart", 32'(md_start), 0);
        chk("t1_cnt", stall_cnt, 6);
        chk("t1_err", 32'(protocol_err), 0);
        chk("t1_idle", 32'(dbg_state), 0);

        // div then divu back to back
        tick();
        d_valid = 1'b1; d_md_op = 4'd3;
        #1 chk("t2_pre_stall", 32'(stall_D), 0);
        tick();
        d_md_op = 4'd4;
        #1;
        chk("t2_start", 32'(md_start), 1);
        chk("t2_opE", 32'(md_op_E), 3);
        chk("t2_stall_t", 32'(stall_D), 1);
        for (int i = 1; i <= 10; i++) begin
            tick(); #1;
            chk("t2_stall_busy", 32'(stall_D), 1);
        end
        tick(); #1;
        chk("t2_release", 32'(stall_D), 0);
        chk("t2_state_end", 32'(dbg_state), 2);
        tick();
        d_md_op = 4'd0;
        #1;
        chk("t2_second_op", 32'(md_op_E), 4);
        chk("t2_second_start", 32'(md_start), 1);
        chk("t2_cnt", stall_cnt, 17);
        chk("t2_idle", 32'(dbg_state), 0);

        // Non-MD instructions stream past while divu runs
        for (int i = 0; i < 11; i++) begin
            tick(); #1;
            chk("t3_no_stall", 32'(stall_D), 0);
        end
        tick(); #1;
        chk("t3_cnt", stall_cnt, 17);
        chk("t3_err", 32'(protocol_err), 0);
        chk("t3_idle", 32'(dbg_state), 0);

        // Flushed mult still launches and is tracked
        d_valid = 1'b1; d_md_op = 4'd1;
        #1 chk("fl_pre_stall", 32'(stall_D), 0);
        tick();
        e_flush = 1'b1; d_md_op = 4'd7;
        #1;
        chk("fl_start", 32'(md_start), 1);
        chk("fl_stall", 32'(stall_D), 1);
        tick();
        e_flush = 1'b0;
        #1;
        chk("fl_slot_clear", 32'(md_op_E), 0);
        chk("fl_stall_busy", 32'(stall_D), 1);
        chk("fl_launch", 32'(dbg_state), 1);
        for (int i = 2; i <= 5; i++) begin
            tick(); #1;
            chk("fl_stall_hold", 32'(stall_D), 1);
        end
        tick(); #1;
        chk("fl_release", 32'(stall_D), 0);
        tick();
        d_valid = 1'b0;
        #1;
        chk("fl_mthi_in_e", 32'(md_op_E), 7);
        chk("fl_cnt", stall_cnt, 23);
        chk("fl_err", 32'(protocol_err), 0);

        // stall_other with MD op in D and the unit idle
        tick();
        d_valid = 1'b1; d_md_op = 4'd5; stall_other = 1'b1;
        #1 chk("so_stall", 32'(stall_D), 0);
        tick();
        stall_other = 1'b0;
        #1 chk("so_bubble", 32'(md_op_E), 0);
        tick();
        d_valid = 1'b0;
        #1;
        chk("so_issue", 32'(md_op_E), 5);
        chk("so_cnt", stall_cnt, 23);

        // Unit drops busy after 3 cycles on a mult
        tick();
        d_valid = 1'b1; d_md_op = 4'd1; short_len = 3;
        tick();
        d_valid = 1'b0;
        #1 chk("er_start", 32'(md_start), 1);
        tick();
        short_len = 0;
        tick(); tick(); tick();
        #1 chk("er_not_yet", 32'(protocol_err), 0);
        tick(); #1;
        chk("er_flag", 32'(protocol_err), 1);
        tick(); tick(); tick(); #1;
        chk("er_sticky", 32'(protocol_err), 1);
        pulse_reset();

        // Spurious busy while idle, plus op 12 treated as none
        tick();
        d_valid = 1'b1; d_md_op = 4'd12; force_busy = 1'b1;
        #1 chk("sp_op12_stall", 32'(stall_D), 0);
        tick();
        force_busy = 1'b0; d_valid = 1'b0;
        #1;
        chk("sp_op12_slot", 32'(md_op_E), 0);
        chk("sp_flag", 32'(protocol_err), 1);
        pulse_reset();

        // Reset in the middle of a div
        tick();
        d_valid = 1'b1; d_md_op = 4'd3;
        tick();
        d_md_op = 4'd7;
        #1 chk("rm_start", 32'(md_start), 1);
        tick(); tick();
        #1 chk("rm_stall", 32'(stall_D), 1);
        #1 reset = 1'b0;
        #1;
        chk("rm_start_off", 32'(md_start), 0);
        chk("rm_opE", 32'(md_op_E), 0);
        chk("rm_stall_off", 32'(stall_D), 0);
        chk("rm_err", 32'(protocol_err), 0);
        chk("rm_cnt", stall_cnt, 0);
        chk("rm_state", 32'(dbg_state), 0);
        reset = 1'b1;
        tick(); #1;
        chk("rm_mthi_in_e", 32'(md_op_E), 7);
        chk("rm_mthi_nostall", 32'(stall_D), 0);
        chk("rm_cnt_after", stall_cnt, 0);
        d_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
